// File: rtl/seq_array_mult_responder.sv
// -----------------------------------------------------------------------------
// seq_array_mult_responder
//   Sequential unsigned multiplier on a valid/ready operand/product interface.
//   Takes one A/B pair per input handshake, runs a shift-add loop that retires
//   one multiplier bit per cycle, then presents the registered product until
//   the consumer takes it. Only one operation is in flight; there is no queue.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand pair on a_in/b_in is valid
//   in_ready   block is IDLE and can take operands
//   a_in       multiplicand, unsigned, INPUT1_WIDTH bits
//   b_in       multiplier, unsigned, INPUT2_WIDTH bits
//   out_valid  product is valid (DONE)
//   out_ready  consumer takes the product
//   product    registered product, INPUT1_WIDTH+INPUT2_WIDTH bits
//   busy       operation in flight (BUSY or DONE)
// -----------------------------------------------------------------------------
module seq_array_mult_responder #(
    parameter int INPUT1_WIDTH = 4,
    parameter int INPUT2_WIDTH = 5
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [INPUT1_WIDTH-1:0]              a_in,
    input  logic [INPUT2_WIDTH-1:0]              b_in,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [INPUT1_WIDTH+INPUT2_WIDTH-1:0] product,
    output logic                                 busy
);

    localparam int P  = INPUT1_WIDTH + INPUT2_WIDTH;
    localparam int CW = $clog2(INPUT2_WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]              r_state;
    logic [P-1:0]            r_mcand;
    logic [INPUT2_WIDTH-1:0] r_mreg;
    logic [P-1:0]            r_acc;
    logic [CW-1:0]           r_cnt;
    logic [P-1:0]            r_product;

    logic [P-1:0]            w_acc_nxt;
    logic                    w_last;
    logic                    w_accept;

    // Accumulator value after the current iteration; also what gets
    // captured into product on the final iteration.
    assign w_acc_nxt = r_acc + (r_mreg[0] ? r_mcand : {P{1'b0}});
    assign w_last    = (r_cnt == CW'(INPUT2_WIDTH - 1));
    assign w_accept  = in_valid && (r_state == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_mreg    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcand <= {{(P-INPUT1_WIDTH){1'b0}}, a_in};
                        r_mreg  <= b_in;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Fixed-length loop: no early exit when the remaining
                    // multiplier bits are zero, so latency is constant.
                    r_acc   <= w_acc_nxt;
                    r_mcand <= r_mcand << 1;
                    r_mreg  <= r_mreg >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_product <= w_acc_nxt;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    // in_valid is ignored here; acceptance waits for IDLE.
                    if (out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign product   = r_product;

endmodule

// File: tb/tb_seq_array_mult_responder.sv
// -----------------------------------------------------------------------------
// tb_seq_array_mult_responder
//   Randomized/directed stimulus with a queue scoreboard. The expected product
//   is plain a*b computed when an input handshake is seen; a monitor pops and
//   compares on every output handshake and checks latency and hold behaviour.
// -----------------------------------------------------------------------------
module tb_seq_array_mult_responder;

    localparam int W1  = 4;
    localparam int W2  = 5;
    localparam int P   = W1 + W2;
    localparam int LAT = W2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W1-1:0] a_in = '0;
    logic [W2-1:0] b_in = '0;
    logic         out_valid;
    logic         out_ready;
    logic [P-1:0] product;
    logic         busy;

    seq_array_mult_responder #(.INPUT1_WIDTH(W1), .INPUT2_WIDTH(W2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int prod; int acc_edge; } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;          // number of rising edges so far
    int bp_mode = 0;        // 0: ready high, 1: random, 2: ready low
    int last_acc = -1;
    int acc_gap  = -1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // out_ready is owned by this process only
    always @(posedge clk or posedge rst) begin
        #1;
        case (bp_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b0;
        endcase
    end
    initial out_ready = 1'b1;

    // Monitor / scoreboard, sampled on the falling edge
    logic         prev_ov = 1'b0;
    logic         prev_hold = 1'b0;
    logic [P-1:0] prev_prod = '0;
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy_decode", int'(busy), int'(!in_ready));
            if (out_valid) chk("ready_in_done", int'(in_ready), 0);
            if (in_valid && in_ready) begin
                exp_t e;
                e.prod = int'(a_in) * int'(b_in);
                e.acc_edge = cyc + 1;
                sb.push_back(e);
                acc_gap  = (last_acc < 0) ? -1 : (cyc + 1 - last_acc);
                last_acc = cyc + 1;
            end
            if (prev_hold) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_product", int'(product), int'(prev_prod));
            end
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) chk("unexpected_out", 1, 0);
                else chk("latency", cyc - sb[0].acc_edge, LAT);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_out", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("product", int'(product), e.prod);
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_ov   = out_valid;
            prev_prod = product;
        end else begin
            prev_hold = 1'b0;
            prev_ov   = 1'b0;
        end
    end

    // Present a pair once in_ready is seen, toggling data while waiting.
    // Returns #1 after the accepting edge; in_valid stays high when hold=1.
    task automatic send(input int a, input int b, input bit hold);
        int n = 0;
        forever begin
            @(posedge clk); #1;
            if (in_ready) break;
            a_in = W1'($urandom); b_in = W2'($urandom);
            if (++n > 200) begin chk("send_timeout", 1, 0); return; end
        end
        a_in = W1'(a); b_in = W2'(b); in_valid = 1'b1;
        @(posedge clk); #1;
        a_in = W1'($urandom); b_in = W2'($urandom);
        in_valid = hold;
    endtask

    task automatic drain();
        int n = 0;
        while (!(sb.size() == 0 && in_ready)) begin
            @(posedge clk); #1;
            if (++n > 300) begin chk("drain_timeout", 1, 0); return; end
        end
    endtask

    initial begin
        int n;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_product", int'(product), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // max operands, in_ready low window
        send(15, 31, 0);
        chk("busy_after_accept", int'(busy), 1);
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            if (++n > 50) break;
        end
        chk("in_ready_low_cycles", n, 6);
        drain();

        send(0, 31, 0);  drain();
        send(9, 0, 0);   drain();

        // backpressure: out_ready low for 3 cycles after out_valid
        bp_mode = 2;
        send(9, 13, 0);
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        chk("bp_valid_seen", int'(out_valid), 1);
        chk("bp_product", int'(product), 117);
        repeat (3) @(negedge clk);
        chk("bp_still_valid", int'(out_valid), 1);
        chk("bp_in_ready", int'(in_ready), 0);
        bp_mode = 0;
        @(posedge clk); @(posedge clk); #1;
        chk("bp_back_idle", int'(in_ready), 1);
        drain();

        // in_valid held high back-to-back, accept spacing 7
        send(3, 7, 1);
        send(15, 1, 1);
        chk("ii_gap_1", acc_gap, W2 + 2);
        send(6, 22, 0);
        chk("ii_gap_2", acc_gap, W2 + 2);
        drain();

        // reset mid-operation
        send(15, 31, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_product", int'(product), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        sb.delete();
        last_acc = -1;
        @(posedge clk); #1 rst = 1'b0;
        send(2, 3, 0);
        drain();

        // exhaustive sweep with random backpressure
        bp_mode = 1;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 32; b++)
                send(a, b, $urandom_range(0, 1));
        in_valid = 1'b0;
        bp_mode = 0;
        drain();
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
